ps2_direction_decoder: RTL

Converts the PS/2 keyboard byte stream into the eight held-direction levels consumed by the processor wrapper's memory-mapped input ports (player 0 at 4100, player 1 at 4101). Player 0 uses the arrow keys (E0-extended codes) and player 1 uses W/A/S/D. Each player's four outputs are registered and at most one is high at a time, so the wrapper always decodes a valid direction (0–4). The block sits between the PS/2 controller and the processor wrapper, which it drives on the `upSig`/`rightSig`/`downSig`/`leftSig` and `...2` inputs.

---
 rtl/ps2_direction_decoder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ps2_direction_decoder.sv
// PS/2 scan-code parser driving held-direction levels for two players.
// Player 0 uses the E0-extended arrow keys, player 1 uses W/A/S/D.
module ps2_direction_decoder #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2_500_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ps2_key_pressed,
    input  logic [7:0] ps2_out,
    output logic       upSig,
    output logic       rightSig,
    output logic       downSig,
    output logic       leftSig,
    output logic       upSig2,
    output logic       rightSig2,
    output logic       downSig2,
    output logic       leftSig2,
    output logic [3:0] held0,
    output logic [3:0] held1
);
    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

    state_t      state, state_nxt;
    logic        key_prev, accept;
    logic [31:0] idle_cnt, idle_cnt_nxt;
    logic        ev_make, ev_brk, ev_ext;
    logic        hit0, hit1;
    logic [1:0]  key0, key1;
    logic [3:0]  dir0, dir1;

    assign accept = ps2_key_pressed & ~key_prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_prev <= 1'b0;
            state    <= IDLE;
            idle_cnt <= '0;
        end else begin
            key_prev <= ps2_key_pressed;
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        ev_make      = 1'b0;
        ev_brk       = 1'b0;
        ev_ext       = 1'b0;
        if (accept) begin
            idle_cnt_nxt = '0;
            case (state)
                IDLE: begin
                    if (ps2_out == 8'hE0)      state_nxt = EXT;
                    else if (ps2_out == 8'hF0) state_nxt = BRK;
                    else                       ev_make   = 1'b1;
                end
                EXT: begin
                    if (ps2_out == 8'hF0)      state_nxt = EXT_BRK;
                    else if (ps2_out != 8'hE0) begin
                        ev_make   = 1'b1;
                        ev_ext    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                BRK: begin
                    ev_brk    = 1'b1;
                    state_nxt = IDLE;
                end
                default: begin
                    ev_brk    = 1'b1;
                    ev_ext    = 1'b1;
                    state_nxt = IDLE;
                end
            endcase
        end else if (state != IDLE) begin
            // An accepted byte takes precedence over the timeout on the same cycle.
            if (idle_cnt == TIMEOUT_CYCLES) begin
                state_nxt    = IDLE;
                idle_cnt_nxt = '0;
            end else begin
                idle_cnt_nxt = idle_cnt + 32'd1;
            end
        end
    end

    always_comb begin
        hit0 = 1'b1;
        key0 = 2'd0;
        case (ps2_out)
            8'h75:   key0 = 2'd0;
            8'h74:   key0 = 2'd1;
            8'h72:   key0 = 2'd2;
            8'h6B:   key0 = 2'd3;
            default: hit0 = 1'b0;
        endcase
        hit1 = 1'b1;
        key1 = 2'd0;
        case (ps2_out)
            8'h1D:   key1 = 2'd0;
            8'h23:   key1 = 2'd1;
            8'h1B:   key1 = 2'd2;
            8'h1C:   key1 = 2'd3;
            default: hit1 = 1'b0;
        endcase
    end

    dir_select u_p0 (
        .clock (clock),
        .reset (reset),
        .make  (ev_make & ev_ext & hit0),
        .brk   (ev_brk & ev_ext & hit0),
        .key   (key0),
        .held  (held0),
        .dir   (dir0)
    );

    dir_select u_p1 (
        .clock (clock),
        .reset (reset),
        .make  (ev_make & ~ev_ext & hit1),
        .brk   (ev_brk & ~ev_ext & hit1),
        .key   (key1),
        .held  (held1),
        .dir   (dir1)
    );

    assign {leftSig, downSig, rightSig, upSig}     = dir0;
    assign {leftSig2, downSig2, rightSig2, upSig2} = dir1;
endmodule

// Per-player held mask and one-hot direction; the last pressed key wins,
// and releasing it falls back to the highest-priority key still held.
module dir_select (
    input  logic       clock,
    input  logic       reset,
    input  logic       make,
    input  logic       brk,
    input  logic [1:0] key,
    output logic [3:0] held,
    output logic [3:0] dir
);
    logic [1:0] last, pick;
    logic       last_valid;
    logic [3:0] key_bit, remaining;

    assign key_bit   = 4'b0001 << key;
    assign remaining = held & ~key_bit;

    always_comb begin
        pick = 2'd3;
        if (remaining[0])      pick = 2'd0;
        else if (remaining[1]) pick = 2'd1;
        else if (remaining[2]) pick = 2'd2;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            held       <= '0;
            dir        <= '0;
            last       <= '0;
            last_valid <= 1'b0;
        end else if (make) begin
            held       <= held | key_bit;
            dir        <= key_bit;
            last       <= key;
            last_valid <= 1'b1;
        end else if (brk) begin
            held <= remaining;
            if (last_valid && key == last) begin
                if (remaining != 4'b0000) begin
                    last <= pick;
                    dir  <= 4'b0001 << pick;
                end else begin
                    dir        <= '0;
                    last_valid <= 1'b0;
                end
            end
        end
    end
endmodule
